receiver_block_reader: RTL and testbench

- Sits directly downstream of the single receiver manager.
- On a start request, snapshots the number of available decoded blocks (avl_blocks_nb). It then indexes each block in turn through block_wanted_number and waits for data_ready.
- Each 41-bit block (17-bit decoded data + 24-bit timestamp) is serialised into a byte frame on a valid/ready byte stream that feeds the host link (SPI/UART transmitter).

---
 rtl/receiver_pkg.sv | 20 ++
 rtl/byte_serializer.sv | 42 ++++
 rtl/receiver_block_reader.sv | 143 ++++++++++++++
 tb/tb_receiver_block_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/receiver_pkg.sv
// Shared widths, frame constants and FSM encoding for the receiver block reader.
package receiver_pkg;

  localparam int DATA_W                = 17;
  localparam int TS_W                  = 24;
  localparam int BLOCK_W               = DATA_W + TS_W;
  localparam int FRAME_BYTES_PER_BLOCK = 6;
  localparam int FRAME_W               = 8 * FRAME_BYTES_PER_BLOCK;

  localparam logic [FRAME_W-1:0] TIMEOUT_FILL = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    WAIT,
    SEND,
    FINISH
  } state_t;

endpackage

// File: rtl/byte_serializer.sv
// 48-bit load/shift register that presents one block group MSB byte first
// on a valid/ready stream and flags acceptance of the final byte.
module byte_serializer
  import receiver_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               ready,
  output logic [7:0]         byte_data,
  output logic               valid,
  output logic               last_byte_accepted
);

  logic [FRAME_W-1:0] shift_reg;
  logic [2:0]         byte_cnt;

  assign byte_data          = shift_reg[FRAME_W-1 -: 8];
  assign last_byte_accepted = valid && ready && (byte_cnt == 3'd0);

  // byte_cnt counts the bytes still to follow the one currently presented
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      byte_cnt  <= 3'd0;
      valid     <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      byte_cnt  <= 3'(FRAME_BYTES_PER_BLOCK - 1);
      valid     <= 1'b1;
    end else if (valid && ready) begin
      shift_reg <= shift_reg << 8;
      if (byte_cnt == 3'd0) begin
        valid <= 1'b0;
      end else begin
        byte_cnt <= byte_cnt - 3'd1;
      end
    end
  end

endmodule

// File: rtl/receiver_block_reader.sv
// Drains the receiver's decoded blocks into a byte frame: header N, then one
// 6-byte group per block, with a per-block timeout that substitutes all-ones.
module receiver_block_reader
  import receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_W           = 7
) (
  input  logic               clk_96MHz,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         avl_blocks_nb,
  input  logic [BLOCK_W-1:0] block_wanted,
  input  logic               data_ready,
  output logic [7:0]         block_wanted_number,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t             state, next_state;
  logic [7:0]         n_blocks;
  logic [7:0]         idx;
  logic [TO_W-1:0]    to_cnt;
  logic               ser_load;
  logic [FRAME_W-1:0] ser_data;
  logic [7:0]         ser_byte;
  logic               ser_valid;
  logic               ser_last;
  logic               got_block;
  logic               timed_out;
  logic               last_block;

  // to_cnt==0 marks the settling cycle right after a new index is presented
  assign got_block  = (state == WAIT) && (to_cnt != '0) && data_ready;
  assign timed_out  = (state == WAIT) && !got_block && (to_cnt == TO_LAST);
  assign last_block = (idx + 8'd1) == n_blocks;

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ser_load   = 1'b0;
    ser_data   = TIMEOUT_FILL;
    case (state)
      IDLE: begin
        if (start) next_state = HEADER;
      end
      HEADER: begin
        if (tx_ready) next_state = (n_blocks == 8'd0) ? FINISH : WAIT;
      end
      WAIT: begin
        if (got_block) begin
          ser_load   = 1'b1;
          ser_data   = FRAME_W'(block_wanted);
          next_state = SEND;
        end else if (timed_out) begin
          ser_load   = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (ser_last) next_state = last_block ? FINISH : WAIT;
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_96MHz or posedge reset) begin
    if (reset) begin
      n_blocks            <= 8'd0;
      idx                 <= 8'd0;
      to_cnt              <= '0;
      block_wanted_number <= 8'd0;
      timeout_err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            n_blocks    <= avl_blocks_nb;
            idx         <= 8'd0;
            timeout_err <= 1'b0;
          end
        end
        HEADER: begin
          if (tx_ready) begin
            block_wanted_number <= idx;
            to_cnt              <= '0;
          end
        end
        WAIT: begin
          to_cnt <= to_cnt + 1'b1;
          if (timed_out) timeout_err <= 1'b1;
        end
        SEND: begin
          if (ser_last) begin
            idx    <= idx + 8'd1;
            to_cnt <= '0;
            if (!last_block) block_wanted_number <= idx + 8'd1;
          end
        end
        FINISH: begin
          block_wanted_number <= 8'd0;
        end
        default: begin
        end
      endcase
    end
  end

  byte_serializer u_serializer (
    .clk                (clk_96MHz),
    .rst                (reset),
    .load               (ser_load),
    .load_data          (ser_data),
    .ready              (tx_ready),
    .byte_data          (ser_byte),
    .valid              (ser_valid),
    .last_byte_accepted (ser_last)
  );

  assign tx_valid = (state == HEADER) || ser_valid;
  assign tx_data  = (state == HEADER) ? n_blocks : (ser_valid ? ser_byte : 8'h00);
  assign busy     = (state == HEADER) || (state == WAIT) || (state == SEND);
  assign done     = (state == FINISH);

endmodule

// File: tb/tb_receiver_block_reader.sv
// Scoreboard bench for receiver_block_reader: expected frame bytes are queued
// at stimulus time and a monitor pops and compares every accepted byte.
module tb_receiver_block_reader;
  import receiver_pkg::*;

  logic               clk_96MHz = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         avl_blocks_nb = 8'd0;
  logic [BLOCK_W-1:0] block_wanted = '0;
  logic               data_ready = 1'b0;
  logic [7:0]         block_wanted_number;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready = 1'b1;
  logic               busy;
  logic               done;
  logic               timeout_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frame_byte = 0;
  int hdr_cyc = 0;
  int data_cyc = 0;
  int last_acc_cyc = 0;
  int done_count = 0;
  int ready_mode = 0;
  int ram_en = 1;

  logic [7:0]         exp_q[$];
  logic [7:0]         exp_byte;
  logic               stall_pending = 1'b0;
  logic [7:0]         held_data = 8'h00;
  logic [BLOCK_W-1:0] mem [0:3];
  logic [7:0]         pipe1 = 8'd0, pipe2 = 8'd0, pipe3 = 8'd0;

  receiver_block_reader dut (
    .clk_96MHz           (clk_96MHz),
    .reset               (reset),
    .start               (start),
    .avl_blocks_nb       (avl_blocks_nb),
    .block_wanted        (block_wanted),
    .data_ready          (data_ready),
    .block_wanted_number (block_wanted_number),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .busy                (busy),
    .done                (done),
    .timeout_err         (timeout_err)
  );

  always #5 clk_96MHz = ~clk_96MHz;

  always @(posedge clk_96MHz) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_group(input logic [47:0] g);
    for (int i = 0; i < 6; i++) exp_q.push_back(g[47-8*i -: 8]);
  endtask

  task automatic applyStimulus(input logic [7:0] n);
    @(posedge clk_96MHz);
    #1;
    avl_blocks_nb = n;
    start = 1'b1;
    frame_byte = 0;
    @(posedge clk_96MHz);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_count;
    int c = 0;
    while (done_count == d0 && c < budget) begin
      @(posedge clk_96MHz);
      c++;
    end
    checkOutput("done_seen", 64'(done_count - d0), 64'd1);
    repeat (4) @(posedge clk_96MHz);
    #1;
    checkOutput("done_pulses", 64'(done_count - d0), 64'd1);
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Receiver RAM model: data follows the requested index after a short pipeline
  initial begin
    mem[0] = 41'h0_1234_ABCDEF;
    mem[1] = 41'h1_FFFF_000001;
    mem[2] = 41'h0_0055_123456;
    mem[3] = 41'h0_0000_000000;
    forever begin
      @(posedge clk_96MHz);
      #1;
      pipe3 = pipe2;
      pipe2 = pipe1;
      pipe1 = block_wanted_number;
      block_wanted = mem[pipe3[1:0]];
      data_ready = (ram_en != 0) && (pipe3 == block_wanted_number);
    end
  end

  // Output-side readiness: always ready, or random with occasional long stalls
  initial begin
    int stall = 0;
    int r;
    forever begin
      @(posedge clk_96MHz);
      #1;
      if (ready_mode == 0) begin
        tx_ready = 1'b1;
      end else if (stall > 0) begin
        tx_ready = 1'b0;
        stall--;
      end else begin
        r = $urandom_range(0, 15);
        if (r == 0) begin
          stall = 20;
          tx_ready = 1'b0;
        end else begin
          tx_ready = r[0];
        end
      end
    end
  end

  always @(negedge clk_96MHz) begin
    if (reset) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        checkOutput("hold_valid", 64'(tx_valid), 64'd1);
        checkOutput("hold_data", 64'(tx_data), 64'(held_data));
      end
      if (tx_valid && tx_ready) begin
        if (frame_byte == 0) hdr_cyc = cyc;
        if (frame_byte == 1) data_cyc = cyc;
        frame_byte++;
        last_acc_cyc = cyc;
        if (exp_q.size() == 0) begin
          checkOutput("extra_byte", 64'(tx_data), 64'hDEAD);
        end else begin
          exp_byte = exp_q.pop_front();
          checkOutput("byte", 64'(tx_data), 64'(exp_byte));
        end
      end
      stall_pending = tx_valid && !tx_ready;
      held_data = tx_data;
      if (done) begin
        done_count++;
        checkOutput("done_latency", 64'(cyc - last_acc_cyc), 64'd1);
        checkOutput("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk_96MHz);
    #1;
    checkOutput("rst_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("rst_tx_data", 64'(tx_data), 64'd0);
    checkOutput("rst_bwn", 64'(block_wanted_number), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_timeout_err", 64'(timeout_err), 64'd0);
    @(negedge clk_96MHz);
    reset = 1'b0;

    $display("[TB] scenario 1: empty frame");
    exp_q.push_back(8'h00);
    applyStimulus(8'd0);
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    wait_done(50);
    checkOutput("n0_bwn", 64'(block_wanted_number), 64'd0);
    checkOutput("n0_timeout_err", 64'(timeout_err), 64'd0);

    $display("[TB] scenario 2: two blocks, always ready");
    exp_q.push_back(8'h02);
    push_group(48'h00_1234_ABCDEF);
    push_group(48'h01_FFFF_000001);
    applyStimulus(8'd2);
    wait_done(300);
    checkOutput("n2_bwn_idle", 64'(block_wanted_number), 64'd0);
    checkOutput("n2_len", 64'(frame_byte), 64'd13);

    $display("[TB] scenario 3: two blocks with backpressure");
    ready_mode = 1;
    exp_q.push_back(8'h02);
    push_group(48'h00_1234_ABCDEF);
    push_group(48'h01_FFFF_000001);
    applyStimulus(8'd2);
    wait_done(3000);
    ready_mode = 0;
    checkOutput("bp_len", 64'(frame_byte), 64'd13);

    $display("[TB] scenario 4: block timeout");
    ram_en = 0;
    exp_q.push_back(8'h01);
    push_group(48'hFFFF_FFFF_FFFF);
    applyStimulus(8'd1);
    wait_done(300);
    ram_en = 1;
    checkOutput("to_err_set", 64'(timeout_err), 64'd1);
    checkOutput("to_latency", 64'(data_cyc - hdr_cyc), 64'd65);
    repeat (5) @(posedge clk_96MHz);
    #1;
    checkOutput("to_err_sticky", 64'(timeout_err), 64'd1);

    $display("[TB] scenario 5: snapshot and ignored start");
    exp_q.push_back(8'h03);
    push_group(48'h00_1234_ABCDEF);
    push_group(48'h01_FFFF_000001);
    push_group(48'h00_0055_123456);
    applyStimulus(8'd3);
    checkOutput("to_err_cleared", 64'(timeout_err), 64'd0);
    repeat (10) @(posedge clk_96MHz);
    #1;
    avl_blocks_nb = 8'd7;
    start = 1'b1;
    @(posedge clk_96MHz);
    #1;
    start = 1'b0;
    wait_done(500);
    checkOutput("snap_len", 64'(frame_byte), 64'd19);

    $display("[TB] scenario 6: reset mid-frame");
    exp_q.push_back(8'h02);
    push_group(48'h00_1234_ABCDEF);
    push_group(48'h01_FFFF_000001);
    applyStimulus(8'd2);
    c = 0;
    while (frame_byte < 3 && c < 200) begin
      @(posedge clk_96MHz);
      c++;
    end
    checkOutput("reached_send", 64'(frame_byte >= 3), 64'd1);
    @(negedge clk_96MHz);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_tx_valid", 64'(tx_valid), 64'd0);
    checkOutput("arst_tx_data", 64'(tx_data), 64'd0);
    checkOutput("arst_busy", 64'(busy), 64'd0);
    checkOutput("arst_done", 64'(done), 64'd0);
    checkOutput("arst_bwn", 64'(block_wanted_number), 64'd0);
    checkOutput("arst_timeout_err", 64'(timeout_err), 64'd0);
    repeat (2) @(posedge clk_96MHz);
    @(negedge clk_96MHz);
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h02);
    push_group(48'h00_1234_ABCDEF);
    push_group(48'h01_FFFF_000001);
    applyStimulus(8'd2);
    wait_done(300);
    checkOutput("post_rst_len", 64'(frame_byte), 64'd13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
